mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//   Iterative MIPS multiply/divide unit beside the execute-stage ALU.
//   Serves mult/multu/div/divu and owns the HI/LO registers. Mfhi/mflo read them; mthi/mtlo write them.
//   Takes one operand pair per start pulse and computes one bit per cycle.
//   Holds busy high while computing so the hazard unit can stall later mf*/md ops.
// PARAMETERS
//   N  32  operand/result width; N >= 2
// PORTS
//   clk        in   1    single clock, rising edge
//   reset      in   1    asynchronous, active-high
//   start      in   1    request; sampled only while busy=0
//   op         in   2    00 mult, 01 multu, 10 div, 11 divu
//   srcA       in   N    multiplicand / dividend
//   srcB       in   N    multiplier / divisor
//   hi_we      in   1    mthi: hi <= wdata
//   lo_we      in   1    mtlo: lo <= wdata
//   wdata      in   N    mthi/mtlo data
//   busy       out  1    operation in flight
//   done       out  1    one-cycle pulse: hi/lo just updated by an op
//   div_zero   out  1    valid with done: divisor was 0
//   hi, lo     out  N    HI/LO registers, always readable
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, hi=lo=0, busy=done=div_zero=0, all internals cleared.
//     Reset aborts an in-flight op; no partial result is written.
//   FSM IDLE -> CALC -> FIN -> IDLE.
//   IDLE: edge with start=1 latches op and operand magnitudes.
//     Signed ops use |x|, computed as an N-bit unsigned negate.
//     Latches result signs: product/quotient sign = A[N-1]^B[N-1]; remainder sign = A[N-1].
//     Sets busy=1, count=N, goes to CALC.
//   CALC: one iteration per edge; count decrements; after N iterations goes to FIN.
//     Mult: shift-add into a 2N-bit accumulator.
//     Div: restoring division, N-bit remainder with an extra carry bit.
//   FIN edge: applies sign correction, writes {hi,lo}, sets done=1 and busy=0, returns to IDLE.
//     Mult: {hi,lo} = 2N-bit product.
//     Div: lo = quotient, hi = remainder.
//   Latency: start sampled at edge 0; results visible after edge N+1 (N=32 -> 33 cycles).
//     busy is high for exactly N+1 cycles; done is high the cycle after.
//   start while busy=1: ignored, not queued.
//   Back-to-back: start may be asserted in the done cycle; it is accepted there.
//   hi_we/lo_we: honoured only when busy=0 and start=0; otherwise dropped.
//     hi_we and lo_we together: both registers written.
//   Divide by zero: no trap. lo = {N{1'b1}}, hi = srcA as latched (signed or not), div_zero=1 with done.
//   Signed overflow, div of -2^(N-1) by -1: lo = 2^(N-1) pattern, hi = 0.
//     Falls out of the magnitude path; no special case needed.
//   Mult never sets div_zero. div_zero is 0 whenever done=0.
// TESTING
//   multu A=FFFFFFFF B=FFFFFFFF -> after 33 cycles done=1, hi=FFFFFFFE, lo=00000001.
//   mult A=FFFFFFFD(-3) B=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1; same via multu -> hi=00000004, lo=FFFFFFF1.
//   div -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF; divu 7/2 -> lo=3, hi=1; div 80000000/FFFFFFFF -> lo=80000000, hi=0.
//   divu A=1234 B=0 -> lo=FFFFFFFF, hi=00001234, div_zero=1 for one cycle with done.
//   start again at cycle 5 of a busy op, and hi_we during busy -> both ignored; first result unchanged.
//     mthi 0xABCD while idle -> hi=ABCD next cycle.
//   reset asserted at cycle 10 of a div (async, mid-cycle) -> busy, hi, lo drop to 0 immediately.
//     No done afterwards; a new op after release completes normally.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// One result bit per cycle; busy covers the whole operation.
module mul_div_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] srcA,
  input  logic [N-1:0] srcB,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic         div_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t         state_q, state_d;
  logic           div_q, div_d;
  logic           neg_res_q, neg_res_d;
  logic           neg_rem_q, neg_rem_d;
  logic [N-1:0]   m_q, m_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic           done_q, done_d;
  logic           dz_q, dz_d;

  logic           sgn;
  logic [N-1:0]   a_mag, b_mag;
  logic [N:0]     sum;
  logic [N:0]     t;
  logic           ge;
  logic [N-1:0]   r_sub;
  logic [2*N-1:0] prod;
  logic [N-1:0]   quo, rem;

  assign sgn   = ~op[0];
  assign a_mag = (sgn && srcA[N-1]) ? -srcA : srcA;
  assign b_mag = (sgn && srcB[N-1]) ? -srcB : srcB;

  // Multiply: add multiplicand to the upper half, then shift right
  assign sum = {1'b0, acc_q[2*N-1:N]} + {1'b0, m_q};

  // Divide: remainder in the upper half, dividend shifts out of the lower
  assign t     = {acc_q[2*N-1:N], acc_q[N-1]};
  assign ge    = t >= {1'b0, m_q};
  assign r_sub = t[N-1:0] - m_q;

  assign prod = neg_res_q ? -acc_q : acc_q;
  assign quo  = neg_res_q ? -acc_q[N-1:0] : acc_q[N-1:0];
  assign rem  = neg_rem_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    m_d       = m_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CALC;
          div_d     = op[1];
          neg_res_d = sgn & (srcA[N-1] ^ srcB[N-1]);
          neg_rem_d = sgn & srcA[N-1];
          m_d       = op[1] ? b_mag : a_mag;
          acc_d     = {{N{1'b0}}, op[1] ? a_mag : b_mag};
          cnt_d     = CW'(N);
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      CALC: begin
        if (div_q) begin
          acc_d = {ge ? r_sub : t[N-1:0],
                   acc_q[N-2:0], ge};
        end else if (acc_q[0]) begin
          acc_d = {sum, acc_q[N-1:1]};
        end else begin
          acc_d = {1'b0, acc_q[2*N-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          // A zero divisor leaves |A| as remainder, so hi already restores A
          dz_d = (m_q == '0);
          lo_d = dz_d ? {N{1'b1}} : quo;
          hi_d = rem;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      m_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit against an arithmetic model.
// Randomized and directed operations, control corner cases, reset.
module tb_mul_div_unit;

  localparam int N = 32;
  localparam int LAT = N + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [N-1:0]  srcA = '0;
  logic [N-1:0]  srcB = '0;
  logic          hi_we = 1'b0;
  logic          lo_we = 1'b0;
  logic [N-1:0]  wdata = '0;
  logic          busy, done, div_zero;
  logic [N-1:0]  hi, lo;

  int n_checks = 0;
  int n_fail = 0;

  mul_div_unit #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .srcA(srcA), .srcB(srcB), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Returns {div_zero, hi, lo}
  function automatic logic [64:0] model(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o[1] == 1'b0) begin
      if (o[0]) p = {32'b0, a} * {32'b0, b};
      else      p = sa * sb;
      return {1'b0, p};
    end
    if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
    if (o[0]) begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, div_zero, hi, lo} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got b%0b d%0b z%0b hi=%h lo=%h want all 0",
               busy, done, div_zero, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed;
    logic [1:0]  t_op [8] = '{2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2};
    logic [31:0] t_a  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFD,
                              32'hFFFFFFF9, 32'd7, 32'h80000000,
                              32'h1234, 32'hFFFFFFF9};
    logic [31:0] t_b  [8] = '{32'hFFFFFFFF, 32'd5, 32'd5, 32'd2, 32'd2,
                              32'hFFFFFFFF, 32'd0, 32'd0};
    logic [64:0] t_e  [8] = '{{1'b0, 32'hFFFFFFFE, 32'h00000001},
                              {1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1},
                              {1'b0, 32'h00000004, 32'hFFFFFFF1},
                              {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD},
                              {1'b0, 32'h00000001, 32'h00000003},
                              {1'b0, 32'h00000000, 32'h80000000},
                              {1'b1, 32'h00001234, 32'hFFFFFFFF},
                              {1'b1, 32'hFFFFFFF9, 32'hFFFFFFFF}};
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], lat);
      n_checks++;
      if (lat !== LAT) begin
        n_fail++;
        $display("FAIL dir%0d_latency got %0d want %0d", i, lat, LAT);
      end
      n_checks++;
      if ({div_zero, hi, lo} !== t_e[i]) begin
        n_fail++;
        $display("FAIL dir%0d_result got z%0b %h_%h want %h",
                 i, div_zero, hi, lo, t_e[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [64:0] e;
    int lat, sel;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(3));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(5);
      if (sel == 0) b = 32'($urandom_range(9));
      if (sel == 1) b = 0;
      if (sel == 2) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if (sel == 3) a = 32'($urandom_range(200));
      e = model(o, a, b);
      run_op(o, a, b, lat);
      n_checks++;
      if (lat !== LAT || {div_zero, hi, lo} !== e) begin
        n_fail++;
        $display("FAIL rand%0d op%0d a=%h b=%h got lat%0d z%0b %h_%h want %h",
                 i, o, a, b, lat, div_zero, hi, lo, e);
      end
    end
  endtask

  task automatic test_div_zero_pulse;
    int lat;
    run_op(2'd3, 32'h1234, 32'd0, lat);
    n_checks++;
    if ({done, div_zero, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL dz_with_done got d%0b z%0b b%0b want 1 1 0",
               done, div_zero, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({done, div_zero} !== 2'b00) begin
      n_fail++;
      $display("FAIL dz_one_cycle got d%0b z%0b want 0 0", done, div_zero);
    end
    run_op(2'd0, 32'd0, 32'd9, lat);
    n_checks++;
    if ({done, div_zero} !== 2'b10) begin
      n_fail++;
      $display("FAIL mult_no_dz got d%0b z%0b want 1 0", done, div_zero);
    end
  endtask

  task automatic test_mthi_mtlo;
    logic [31:0] h0, l0;
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hABCD;
    l0 = lo;
    @(posedge clk); #1;
    hi_we = 1'b0;
    n_checks++;
    if (hi !== 32'hABCD || lo !== l0) begin
      n_fail++;
      $display("FAIL mthi got hi=%h lo=%h want %h %h", hi, lo, 32'hABCD, l0);
    end
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h5555AAAA;
    @(posedge clk); #1;
    lo_we = 1'b0;
    n_checks++;
    if (hi !== 32'hABCD || lo !== 32'h5555AAAA) begin
      n_fail++;
      $display("FAIL mtlo got hi=%h lo=%h want ABCD 5555AAAA", hi, lo);
    end
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0F0F1234;
    @(posedge clk); #1;
    n_checks++;
    if (hi !== 32'h0F0F1234 || lo !== 32'h0F0F1234) begin
      n_fail++;
      $display("FAIL mt_both got hi=%h lo=%h want 0F0F1234", hi, lo);
    end
    // Write alongside start must be dropped
    h0 = hi; l0 = lo;
    @(negedge clk);
    wdata = 32'hDEAD0000; start = 1'b1; op = 2'd3;
    srcA = 32'd1000; srcB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    n_checks++;
    if (hi !== h0 || lo !== l0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mt_with_start got hi=%h lo=%h b%0b want %h %h 1",
               hi, lo, busy, h0, l0);
    end
    begin
      int lat;
      wait_done(lat);
    end
  endtask

  task automatic test_ignore_busy;
    int lat, extra;
    @(negedge clk);
    start = 1'b1; op = 2'd3; srcA = 32'd1000; srcB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    start = 1'b1; op = 2'd1; srcA = 32'hFFFF; srcB = 32'hFFFF;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    wait_done(lat);
    n_checks++;
    if (lat + 5 !== LAT || hi !== 32'd6 || lo !== 32'd142) begin
      n_fail++;
      $display("FAIL busy_ignore got lat%0d hi=%h lo=%h want %0d 6 142",
               lat + 5, hi, lo, LAT);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (busy || done) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL busy_not_queued got %0d busy cycles want 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [64:0] e;
    run_op(2'd1, 32'h10000, 32'h10000, lat);
    start = 1'b1; op = 2'd2; srcA = 32'hFFFFFF9C; srcB = 32'd7;
    e = model(2'd2, 32'hFFFFFF9C, 32'd7);
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if ({busy, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_accept got b%0b d%0b want 1 0", busy, done);
    end
    wait_done(lat);
    n_checks++;
    if (lat !== LAT || {div_zero, hi, lo} !== e) begin
      n_fail++;
      $display("FAIL b2b_result got lat%0d z%0b %h_%h want %0d %h",
               lat, div_zero, hi, lo, LAT, e);
    end
  endtask

  task automatic test_reset_mid;
    int lat, seen;
    run_op(2'd1, 32'hFFFFFFFF, 32'd2, lat);
    @(negedge clk);
    start = 1'b1; op = 2'd2; srcA = 32'd12345; srcB = 32'd11;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, hi, lo} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid got b%0b d%0b hi=%h lo=%h want 0",
               busy, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_abort got %0d active cycles want 0", seen);
    end
    run_op(2'd3, 32'd100, 32'd7, lat);
    n_checks++;
    if (lat !== LAT || hi !== 32'd2 || lo !== 32'd14) begin
      n_fail++;
      $display("FAIL reset_recover got lat%0d hi=%h lo=%h want %0d 2 14",
               lat, hi, lo, LAT);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_div_zero_pulse;
    test_mthi_mtlo;
    test_ignore_busy;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
